round_sequencer: RTL and testbench

Game-flow controller for the two-player bell game. It deals card pairs on a fixed tick schedule and measures reaction time per reveal. It arbitrates the two bell buttons, including simultaneous presses, and judges each press. It then hands one scored event per round to the score datapath through a valid/ready handshake. It sits between the debounced bell inputs and score_control/score_file, and replaces the free-running keypad decode path.

---
 rtl/game_pkg.sv | 36 +++
 rtl/card_lfsr.sv | 35 +++
 rtl/round_sequencer.sv | 177 +++++++++++++++++
 tb/tb_round_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the bell game controller and score-side checks.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_WAIT_BELL,
        S_ISSUE,
        S_COOLDOWN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] color;
        logic [2:0] num;
    } card_t;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_P1   = 2'b01;
    localparam logic [1:0] WHO_P2   = 2'b10;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [2:0] mod5_plus1(input logic [2:0] v);
        return (v < 3'd5) ? v + 3'd1 : v - 3'd4;
    endfunction

    function automatic logic judge_right(input card_t a, input card_t b);
        logic [3:0] sum;
        sum = {1'b0, a.num} + {1'b0, b.num};
        if (a.color == b.color) return sum == 4'd5;
        return (a.num == 3'd5) || (b.num == 3'd5);
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running card source: 16-bit LFSR mapped to a card pair, with an
// external override used to force known deals.
module card_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_sel,
    input  logic [9:0] cards_ext,
    output card_t      card1,
    output card_t      card2
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) lfsr <= SEED;
        else      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    always_comb begin
        if (ext_sel) begin
            card1 = card_t'(cards_ext[9:5]);
            card2 = card_t'(cards_ext[4:0]);
        end else begin
            card1.color = lfsr[4:3];
            card1.num   = mod5_plus1(lfsr[2:0]);
            card2.color = lfsr[9:8];
            card2.num   = mod5_plus1(lfsr[7:5]);
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Bell game flow: deal, time reactions, arbitrate bells, hand one event per round
// to the score path.
//   state       | meaning
//   S_IDLE      | after reset, waiting for start
//   S_DEAL      | one cycle: draw cards, restart tick/reveal/count timers
//   S_WAIT_BELL | counting reaction ticks, redrawing every REVEAL_TICKS ticks
//   S_ISSUE     | event held on ev_* until ev_ready
//   S_COOLDOWN  | COOLDOWN_TICKS ticks before the next deal
//   S_DONE      | game over, cards held, waiting for start
module round_sequencer
    import game_pkg::*;
#(
    parameter int          TICK_DIV       = 4,
    parameter int          REVEAL_TICKS   = 8,
    parameter int          COOLDOWN_TICKS = 4,
    parameter int          MAX_ROUNDS     = 16,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bell1,
    input  logic       bell2,
    input  logic       ext_sel,
    input  logic [9:0] cards_ext,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_who,
    output logic       ev_right,
    output logic [7:0] ev_count,
    output logic [4:0] round,
    output logic       game_over
);

    localparam int DW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REVEAL_TICKS + 1);
    localparam int CW = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [DW-1:0] DIV_LOAD   = DW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REV_LOAD   = RW'(REVEAL_TICKS - 1);
    localparam logic [CW-1:0] CD_LOAD    = CW'(COOLDOWN_TICKS - 1);
    localparam logic [4:0]    LAST_ROUND = 5'(MAX_ROUNDS);

    state_t        state;
    logic [DW-1:0] div;
    logic [RW-1:0] rv;
    logic [CW-1:0] cd;
    logic [7:0]    count;
    logic          bell1_q, bell2_q;
    logic          rr_prio;
    card_t         card1_q, card2_q;
    card_t         draw1, draw2;
    logic          press1, press2, win_p2, tick, reveal;

    card_lfsr #(.SEED(SEED)) u_card_lfsr (
        .clk       (clk),
        .rst       (rst),
        .ext_sel   (ext_sel),
        .cards_ext (cards_ext),
        .card1     (draw1),
        .card2     (draw2)
    );

    assign press1 = bell1 & ~bell1_q;
    assign press2 = bell2 & ~bell2_q;
    // rr_prio = 1 hands a tie to player 2
    assign win_p2 = press2 & (~press1 | rr_prio);
    assign tick   = (div == '0);
    assign reveal = tick && (rv == '0);

    assign c1 = card1_q.color;
    assign n1 = card1_q.num;
    assign c2 = card2_q.color;
    assign n2 = card2_q.num;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            div       <= '0;
            rv        <= '0;
            cd        <= '0;
            count     <= '0;
            bell1_q   <= 1'b0;
            bell2_q   <= 1'b0;
            rr_prio   <= 1'b0;
            card1_q   <= '0;
            card2_q   <= '0;
            ev_valid  <= 1'b0;
            ev_who    <= WHO_NONE;
            ev_right  <= 1'b0;
            ev_count  <= '0;
            round     <= '0;
            game_over <= 1'b0;
        end else begin
            bell1_q <= bell1;
            bell2_q <= bell2;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        round <= '0;
                        state <= S_DEAL;
                    end
                end
                S_DEAL: begin
                    card1_q <= draw1;
                    card2_q <= draw2;
                    div     <= DIV_LOAD;
                    rv      <= REV_LOAD;
                    count   <= '0;
                    state   <= S_WAIT_BELL;
                end
                S_WAIT_BELL: begin
                    if (press1 | press2) begin
                        // judged on the cards on show, so a coinciding reveal is dropped
                        ev_valid <= 1'b1;
                        ev_who   <= win_p2 ? WHO_P2 : WHO_P1;
                        ev_right <= judge_right(card1_q, card2_q);
                        ev_count <= count;
                        if (press1 & press2) rr_prio <= ~rr_prio;
                        state    <= S_ISSUE;
                    end else if (tick) begin
                        div <= DIV_LOAD;
                        if (reveal) begin
                            card1_q <= draw1;
                            card2_q <= draw2;
                            count   <= '0;
                            rv      <= REV_LOAD;
                        end else begin
                            rv <= rv - 1'b1;
                            if (count != 8'hFF) count <= count + 8'd1;
                        end
                    end else begin
                        div <= div - 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        ev_who   <= WHO_NONE;
                        ev_right <= 1'b0;
                        ev_count <= '0;
                        round    <= round + 5'd1;
                        if (round + 5'd1 == LAST_ROUND) begin
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            div   <= DIV_LOAD;
                            cd    <= CD_LOAD;
                            state <= S_COOLDOWN;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (tick) begin
                        div <= DIV_LOAD;
                        if (cd == '0) state <= S_DEAL;
                        else          cd    <= cd - 1'b1;
                    end else begin
                        div <= div - 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        round     <= '0;
                        game_over <= 1'b0;
                        state     <= S_DEAL;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed round table, reset and LFSR
// sequences, then randomized rounds against a cycle-count reference model.
module tb_round_sequencer;
    import game_pkg::*;

    localparam int T    = 2;
    localparam int R    = 300;
    localparam int C    = 3;
    localparam int MAXR = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, bell1 = 1'b0, bell2 = 1'b0;
    logic       ext_sel = 1'b1, ev_ready = 1'b0;
    logic [9:0] cards_ext = '0;
    logic [1:0] c1, c2, ev_who;
    logic [2:0] n1, n2;
    logic       ev_valid, ev_right, game_over;
    logic [7:0] ev_count;
    logic [4:0] round;

    round_sequencer #(
        .TICK_DIV(T), .REVEAL_TICKS(R), .COOLDOWN_TICKS(C), .MAX_ROUNDS(MAXR), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bell1(bell1), .bell2(bell2),
        .ext_sel(ext_sel), .cards_ext(cards_ext), .c1(c1), .c2(c2), .n1(n1), .n2(n2),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_who(ev_who), .ev_right(ev_right),
        .ev_count(ev_count), .round(round), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR; m_prev is the value the DUT drew from at the last edge.
    logic [15:0] m_lfsr, m_prev;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_next(m_lfsr);
        m_prev <= m_lfsr;
    end

    typedef struct {
        logic [9:0] cards;
        logic [9:0] alt;
        logic [1:0] bells;
        int         k;
        int         off;
        int         rdelay;
        bit         early;
        bit         deal_press;
        logic [1:0] exp_who;
        bit         exp_right;
        logic [7:0] exp_count;
    } vec_t;

    int         n_tests = 0, n_fail = 0;
    int         d;
    int         exp_round;
    bit         p_prio;
    logic [9:0] shown;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic [9:0] cardv(input int a, input int b, input int x, input int y);
        return {2'(a), 3'(b), 2'(x), 3'(y)};
    endfunction

    function automatic logic [9:0] cards_out();
        return {c1, n1, c2, n2};
    endfunction

    function automatic logic [27:0] all_out();
        return {c1, n1, c2, n2, ev_valid, ev_who, ev_right, ev_count, round, game_over};
    endfunction

    function automatic bit ref_right(input logic [9:0] cx);
        int a, b, x, y;
        a = int'(cx[9:8]); b = int'(cx[7:5]); x = int'(cx[4:3]); y = int'(cx[2:0]);
        if (a == x) return ((b + y) % 16) == 5;
        return (b == 5) || (y == 5);
    endfunction

    function automatic logic [9:0] lfsr_cards(input logic [15:0] s);
        int a, b;
        a = int'(s[2:0]) % 5 + 1;
        b = int'(s[7:5]) % 5 + 1;
        return {s[4:3], 3'(a), s[9:8], 3'(b)};
    endfunction

    function automatic vec_t mk(input logic [9:0] cards, input logic [9:0] alt, input logic [1:0] bells,
                                input int k, input int off, input int rdelay, input bit early,
                                input bit dp, input logic [1:0] who, input bit right, input int count);
        vec_t v;
        v.cards = cards; v.alt = alt; v.bells = bells; v.k = k; v.off = off;
        v.rdelay = rdelay; v.early = early; v.deal_press = dp;
        v.exp_who = who; v.exp_right = right; v.exp_count = 8'(count);
        return v;
    endfunction

    // One full round starting from the known deal edge d; leaves d at the next deal.
    task automatic run_round(input vec_t v);
        int p, a;
        logic [9:0] eff;
        wait_until(d - 1);
        check("held_cards", 32'(cards_out()), 32'(shown));
        cards_ext = v.cards;
        ev_ready  = 1'b0;
        if (v.deal_press) bell1 = 1'b1;
        step(1);
        check("deal_cards", 32'(cards_out()), 32'(v.cards));
        cards_ext = v.alt;
        if (v.early) ev_ready = 1'b1;
        if (v.deal_press) begin
            step(3);
            check("deal_press_ignored", 32'(ev_valid), 32'd0);
            bell1 = 1'b0;
        end
        p = d + T * v.k + 1 + v.off;
        if (v.k >= R) begin
            wait_until(d + R * T - 1);
            check("pre_reveal_cards", 32'(cards_out()), 32'(v.cards));
            step(1);
            check("reveal_cards", 32'(cards_out()), 32'(v.alt));
        end
        wait_until(p - 1);
        check("no_early_event", 32'(ev_valid), 32'd0);
        bell1 = v.bells[0];
        bell2 = v.bells[1];
        step(1);
        eff = (v.k >= R) ? v.alt : v.cards;
        check("event", 32'({ev_valid, ev_who, ev_right, ev_count}),
              32'({1'b1, v.exp_who, v.exp_right, v.exp_count}));
        check("round_in_issue", 32'(round), 32'(exp_round));
        check("cards_at_press", 32'(cards_out()), 32'(eff));
        bell1 = 1'b0;
        bell2 = 1'b0;
        if (v.bells == 2'b11) p_prio = ~p_prio;
        if (!v.early) begin
            repeat (v.rdelay) begin
                step(1);
                check("payload_stable", 32'({ev_valid, ev_who, ev_right, ev_count}),
                      32'({1'b1, v.exp_who, v.exp_right, v.exp_count}));
            end
            ev_ready = 1'b1;
        end
        step(1);
        a = cyc;
        ev_ready = 1'b0;
        exp_round++;
        check("accepted_payload_clear", 32'({ev_valid, ev_who, ev_right, ev_count}), 32'd0);
        check("round_after_accept", 32'(round), 32'(exp_round));
        shown = eff;
        if (exp_round == MAXR) begin
            check("game_over", 32'(game_over), 32'd1);
            start = 1'b1;
            step(1);
            start = 1'b0;
            check("restart_round", 32'({round, game_over}), 32'd0);
            check("restart_state", 32'(dut.state), 32'(S_DEAL));
            exp_round = 0;
            d = a + 2;
        end else begin
            check("not_over", 32'(game_over), 32'd0);
            d = a + C * T + 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        int   p, kk;

        tbl[0] = mk(cardv(1,2,1,3), cardv(1,2,1,3), 2'b01,   3, 0, 0, 0, 0, 2'b01, 1,   3);
        tbl[1] = mk(cardv(0,4,2,1), cardv(0,4,2,1), 2'b10,   5, 1, 5, 0, 0, 2'b10, 0,   5);
        tbl[2] = mk(cardv(3,5,0,1), cardv(3,5,0,1), 2'b11,   0, 0, 1, 0, 0, 2'b01, 1,   0);
        tbl[3] = mk(cardv(2,4,2,4), cardv(2,4,2,4), 2'b11,   7, 1, 0, 1, 0, 2'b10, 0,   7);
        tbl[4] = mk(cardv(2,1,2,4), cardv(2,1,2,4), 2'b01,   4, 0, 2, 0, 1, 2'b01, 1,   4);
        tbl[5] = mk(cardv(0,1,1,2), cardv(1,2,1,3), 2'b01, 303, 0, 0, 0, 0, 2'b01, 1,   3);
        tbl[6] = mk(cardv(0,1,1,2), cardv(0,5,3,1), 2'b10, 280, 0, 1, 0, 0, 2'b10, 0, 255);
        tbl[7] = mk(cardv(3,2,3,3), cardv(0,1,1,2), 2'b01, 299, 1, 0, 0, 0, 2'b01, 1, 255);
        tbl[8] = mk(cardv(0,1,1,2), cardv(2,3,1,5), 2'b10, 305, 0, 0, 1, 0, 2'b10, 1,   5);

        // reset values, then one LFSR deal checked against the reference draw
        ext_sel = 1'b0;
        step(2);
        check("reset_outputs", 32'(all_out()), 32'd0);
        check("reset_state", 32'(dut.state), 32'(S_IDLE));
        rst   = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("lfsr_deal", 32'(cards_out()), 32'(lfsr_cards(m_prev)));

        rst     = 1'b0;
        ext_sel = 1'b1;
        step(1);
        check("reset_after_deal", 32'(all_out()), 32'd0);
        rst   = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        d = cyc + 1;
        shown = '0;
        exp_round = 0;
        p_prio = 1'b0;

        for (int i = 0; i < 9; i++) run_round(tbl[i]);

        // reset while an event is pending, with bell1 held through reset
        wait_until(d - 1);
        cards_ext = cardv(1,1,2,2);
        step(1);
        p = d + 2 * T + 1;
        wait_until(p - 1);
        bell1 = 1'b1;
        step(1);
        check("issue_before_reset", 32'(ev_valid), 32'd1);
        rst = 1'b0;
        step(1);
        check("reset_in_issue", 32'(all_out()), 32'd0);
        check("reset_in_issue_state", 32'(dut.state), 32'(S_IDLE));
        rst   = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        d = cyc + 1;
        shown = '0;
        exp_round = 0;
        p_prio = 1'b0;
        run_round(mk(cardv(2,3,0,5), cardv(2,3,0,5), 2'b10, 6, 1, 1, 0, 1, 2'b10, 1, 6));

        // randomized rounds checked against the reference model
        for (int i = 0; i < 30; i++) begin
            v.cards      = cardv($urandom_range(0,3), $urandom_range(1,5),
                                 $urandom_range(0,3), $urandom_range(1,5));
            v.alt        = v.cards;
            v.bells      = 2'($urandom_range(1,3));
            v.deal_press = ($urandom_range(0,4) == 0);
            kk           = v.deal_press ? int'($urandom_range(2,12)) : int'($urandom_range(0,12));
            v.k          = kk;
            v.off        = $urandom_range(0, T-1);
            v.rdelay     = $urandom_range(0,4);
            v.early      = ($urandom_range(0,3) == 0);
            v.exp_who    = (v.bells == 2'b11) ? (p_prio ? 2'b10 : 2'b01) : v.bells;
            v.exp_right  = ref_right(v.cards);
            v.exp_count  = ((kk % R) > 255) ? 8'd255 : 8'(kk % R);
            run_round(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
